// File: rtl/mmio_timer_if.sv
// Processor data-bus view of the timer: store strobe, byte address and store
// data in; combinational read data, window hit and level interrupt out.
interface mmio_timer_if;
  logic        WE;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        hit;
  logic        irq;

  // There is no valid/ready pair. A store is accepted on the rising clk edge
  // whenever WE=1 and hit=1, so it always completes in one cycle. A read is
  // simply A in and RD out in the same cycle, with no strobe.
  modport master (output WE, output A, output WD, input RD, input hit, input irq);
  modport slave  (input WE, input A, input WD, output RD, output hit, output irq);
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped down-counter timer: prescaler, one-shot/auto-reload, sticky
// expiry flag and level interrupt in a 16-byte window on the data bus.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0010,
  parameter int          PRESCALE_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  mmio_timer_if.slave bus
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic                  en, en_n;
  logic                  auto_reload, auto_reload_n;
  logic                  irq_en, irq_en_n;
  logic [PRESCALE_W-1:0] prescale, prescale_n;
  logic [PRESCALE_W-1:0] pc, pc_n;
  logic [31:0]           load, load_n;
  logic [31:0]           count, count_n;
  logic                  flag, flag_n;

  logic [1:0]  idx;
  logic        wr;
  logic        wr_ctrl, wr_load, wr_count, wr_status;
  logic        tick, tick_eff, expire;
  logic [31:0] ctrl_rd;
  logic        unused_addr_lsbs;

  assign bus.hit = (bus.A[31:4] == BASE_ADDR[31:4]);
  assign idx     = bus.A[3:2];
  assign unused_addr_lsbs = &{1'b0, bus.A[1:0]};

  assign wr        = bus.WE & bus.hit;
  assign wr_ctrl   = wr & (idx == REG_CTRL);
  assign wr_load   = wr & (idx == REG_LOAD);
  assign wr_count  = wr & (idx == REG_COUNT);
  assign wr_status = wr & (idx == REG_STATUS);

  // A software write to LOAD or COUNT swallows a coincident tick entirely,
  // including any expiry it would have caused.
  assign tick     = en & (pc == prescale);
  assign tick_eff = tick & ~(wr_load | wr_count);
  assign expire   = tick_eff & (count == '0);

  always_comb begin
    en_n          = en;
    auto_reload_n = auto_reload;
    irq_en_n      = irq_en;
    prescale_n    = prescale;
    load_n        = load;
    count_n       = count;
    flag_n        = flag;
    pc_n          = tick ? '0 : pc + PRESCALE_W'(1);

    if (tick_eff) begin
      if (count != '0) begin
        count_n = count - 32'd1;
      end else if (auto_reload) begin
        count_n = load;
      end else begin
        en_n = 1'b0;
      end
    end

    // Set beats a simultaneous write-1-to-clear.
    if (wr_status && bus.WD[0]) flag_n = 1'b0;
    if (expire) flag_n = 1'b1;

    if (wr_ctrl) begin
      en_n          = bus.WD[0];
      auto_reload_n = bus.WD[1];
      irq_en_n      = bus.WD[2];
      prescale_n    = bus.WD[8 +: PRESCALE_W];
      if (!en && bus.WD[0]) pc_n = '0;
    end

    if (wr_load) begin
      load_n  = bus.WD;
      count_n = bus.WD;
      pc_n    = '0;
    end

    if (wr_count) begin
      count_n = bus.WD;
      pc_n    = '0;
    end

    if (!en_n) pc_n = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en          <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      prescale    <= '0;
      pc          <= '0;
      load        <= '0;
      count       <= '0;
      flag        <= 1'b0;
    end else begin
      en          <= en_n;
      auto_reload <= auto_reload_n;
      irq_en      <= irq_en_n;
      prescale    <= prescale_n;
      pc          <= pc_n;
      load        <= load_n;
      count       <= count_n;
      flag        <= flag_n;
    end
  end

  always_comb begin
    ctrl_rd                     = '0;
    ctrl_rd[0]                  = en;
    ctrl_rd[1]                  = auto_reload;
    ctrl_rd[2]                  = irq_en;
    ctrl_rd[8 +: PRESCALE_W]    = prescale;
  end

  always_comb begin
    bus.RD = '0;
    if (bus.hit) begin
      case (idx)
        REG_CTRL:   bus.RD = ctrl_rd;
        REG_LOAD:   bus.RD = load;
        REG_COUNT:  bus.RD = count;
        default:    bus.RD = {31'd0, flag};
      endcase
    end
  end

  assign bus.irq = flag & irq_en;

endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: reset checks, a decode vector table, hand-written
// timing sequences and a randomized run against a behavioural model.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'hFFFF_0010;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mmio_timer_if bus ();

  mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  // CTRL held as the masked word software would read back.
  logic [31:0] m_ctrl, m_load, m_count;
  logic        m_flag;
  int          m_pc;

  task automatic model_reset();
    m_ctrl = 0; m_load = 0; m_count = 0; m_flag = 0; m_pc = 0;
  endtask

  task automatic model_edge();
    logic        w, tk, sw, set_now;
    logic [1:0]  ix;
    logic [31:0] nc, nl, ncnt;
    logic        nf;
    int          npc;
    w   = bus.WE && (bus.A[31:4] == BASE[31:4]);
    ix  = bus.A[3:2];
    tk  = m_ctrl[0] && (m_pc == int'(m_ctrl[15:8]));
    sw  = w && (ix == 2'd1 || ix == 2'd2);
    nc = m_ctrl; nl = m_load; ncnt = m_count; nf = m_flag; npc = m_pc;
    set_now = 0;
    if (m_ctrl[0]) npc = tk ? 0 : (m_pc + 1) % 256;
    if (tk && !sw) begin
      if (m_count != 0) ncnt = m_count - 1;
      else begin
        set_now = 1;
        nf = 1;
        if (m_ctrl[1]) ncnt = m_load;
        else begin nc[0] = 0; npc = 0; end
      end
    end
    if (w) begin
      case (ix)
        2'd0: begin
          if (!m_ctrl[0] && bus.WD[0]) npc = 0;
          nc = bus.WD & 32'h0000_FF07;
          if (!nc[0]) npc = 0;
        end
        2'd1: begin nl = bus.WD; ncnt = bus.WD; npc = 0; end
        2'd2: begin ncnt = bus.WD; npc = 0; end
        default: if (bus.WD[0] && !set_now) nf = 0;
      endcase
    end
    m_ctrl = nc; m_load = nl; m_count = ncnt; m_flag = nf; m_pc = npc;
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] ix);
    case (ix)
      2'd0:    return m_ctrl;
      2'd1:    return m_load;
      2'd2:    return m_count;
      default: return {31'd0, m_flag};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.WE = 1'b1; bus.A = a; bus.WD = d;
    step();
    bus.WE = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.WE = 1'b0; bus.A = a;
    #1;
    d = bus.RD;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reg(input string nm, input logic [1:0] ix, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(BASE + {28'd0, ix, 2'b00}, d);
    chk(nm, d, exp);
  endtask

  task automatic chk_model(input int cyc);
    logic [31:0] d;
    logic [31:0] q[$];
    for (int i = 0; i < 4; i++) begin
      bus_read(BASE + 32'(i * 4) + 32'($urandom_range(0, 3)), d);
      q.push_back(model_rd(2'(i)));
      chk($sformatf("rnd_reg%0d_c%0d", i, cyc), d, q.pop_front());
    end
    chk($sformatf("rnd_irq_c%0d", cyc), {31'd0, bus.irq}, {31'd0, m_flag & m_ctrl[2]});
    chk($sformatf("rnd_hit_c%0d", cyc), {31'd0, bus.hit}, 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] ra;
    logic [31:0] exp_rd;
    logic        exp_hit;
  } vec_t;

  vec_t tbl[10];

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] d;
    bus.WE = 0; bus.A = 0; bus.WD = 0;
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    step();

    for (int i = 0; i < 4; i++) chk($sformatf("reset_reg%0d", i), 32'd0, 32'd0 | model_rd(2'(i)) ^ 32'd0) ;
    for (int i = 0; i < 4; i++) chk_reg($sformatf("reset_rd%0d", i), 2'(i), 32'd0);
    chk("reset_irq", {31'd0, bus.irq}, 32'd0);

    // decode vectors; timer stays disabled so reads are static
    tbl[0] = '{1'b1, BASE + 32'h4,  32'h1234_5678, BASE + 32'h8,  32'h1234_5678, 1'b1};
    tbl[1] = '{1'b1, BASE + 32'h10, 32'h0000_0007, BASE + 32'h10, 32'h0,         1'b0};
    tbl[2] = '{1'b1, BASE - 32'h4,  32'h0000_AAAA, BASE + 32'h4,  32'h1234_5678, 1'b1};
    tbl[3] = '{1'b0, BASE,          32'h0,         BASE,          32'h0,         1'b1};
    tbl[4] = '{1'b0, BASE,          32'h0,         BASE + 32'h0B, 32'h1234_5678, 1'b1};
    tbl[5] = '{1'b1, BASE,          32'hFFFF_FFFA, BASE,          32'h0000_FF02, 1'b1};
    tbl[6] = '{1'b0, BASE + 32'h8,  32'h5,         BASE + 32'h8,  32'h1234_5678, 1'b1};
    tbl[7] = '{1'b1, BASE + 32'hC,  32'h1,         BASE + 32'hC,  32'h0,         1'b1};
    tbl[8] = '{1'b1, BASE,          32'h0,         BASE,          32'h0,         1'b1};
    tbl[9] = '{1'b1, BASE + 32'h9,  32'h55,        BASE + 32'h8,  32'h55,        1'b1};
    for (int i = 0; i < 10; i++) begin
      bus.WE = tbl[i].we; bus.A = tbl[i].a; bus.WD = tbl[i].wd;
      step();
      bus.WE = 1'b0;
      bus_read(tbl[i].ra, d);
      chk($sformatf("vec%0d_rd", i), d, tbl[i].exp_rd);
      chk($sformatf("vec%0d_hit", i), {31'd0, bus.hit}, {31'd0, tbl[i].exp_hit});
    end

    // one-shot, PRESCALE=0
    bus_write(BASE + 32'h4, 32'd3);
    bus_write(BASE, 32'h1);
    chk_reg("os_cnt0", 2'd2, 32'd3);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_reg($sformatf("os_cnt%0d", k), 2'd2, (k < 3) ? 32'(3 - k) : 32'd0);
      chk_reg($sformatf("os_flag%0d", k), 2'd3, (k >= 4) ? 32'd1 : 32'd0);
      chk_reg($sformatf("os_ctrl%0d", k), 2'd0, (k >= 4) ? 32'd0 : 32'd1);
    end
    bus_write(BASE + 32'hC, 32'h1);

    // auto-reload, PRESCALE=2, IRQ_EN
    bus_write(BASE + 32'h4, 32'd2);
    bus_write(BASE, 32'h0000_0207);
    for (int k = 1; k <= 9; k++) begin
      step();
      chk_reg($sformatf("ar_cnt%0d", k), 2'd2,
              (k < 3) ? 32'd2 : (k < 6) ? 32'd1 : (k < 9) ? 32'd0 : 32'd2);
      chk($sformatf("ar_irq%0d", k), {31'd0, bus.irq}, (k == 9) ? 32'd1 : 32'd0);
    end
    bus_write(BASE + 32'hC, 32'h1);
    chk("ar_irq_clr", {31'd0, bus.irq}, 32'd0);
    for (int k = 11; k <= 18; k++) begin
      step();
      chk($sformatf("ar_irq%0d", k), {31'd0, bus.irq}, (k == 18) ? 32'd1 : 32'd0);
    end

    // tick at COUNT==0 coinciding with a FLAG clear, then with a COUNT write
    bus_write(BASE, 32'h0);
    bus_write(BASE + 32'hC, 32'h1);
    bus_write(BASE + 32'h4, 32'd0);
    bus_write(BASE, 32'h3);
    chk_reg("sw_flag_pre", 2'd3, 32'd0);
    bus_write(BASE + 32'hC, 32'h1);
    chk_reg("sw_set_wins", 2'd3, 32'd1);
    bus_write(BASE + 32'h8, 32'h10);
    chk_reg("sw_cnt_write", 2'd2, 32'h10);
    step();
    chk_reg("sw_cnt_dec", 2'd2, 32'hF);

    // async reset while counting with irq high
    bus_write(BASE + 32'h4, 32'd100);
    bus_write(BASE, 32'h7);
    step(); step();
    chk("rst_irq_pre", {31'd0, bus.irq}, 32'd1);
    bus.A = BASE + 32'h8;
    #2 reset = 1'b0;
    #1 chk("rst_async_cnt", bus.RD, 32'd0);
    chk("rst_async_irq", {31'd0, bus.irq}, 32'd0);
    chk_reg("rst_async_ctrl", 2'd0, 32'd0);
    chk_reg("rst_async_flag", 2'd3, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    step();
    for (int i = 0; i < 4; i++) chk_reg($sformatf("rst_rel%0d", i), 2'(i), 32'd0);
    step(); step();
    chk_reg("rst_idle_cnt", 2'd2, 32'd0);

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      int r;
      logic [31:0] wd;
      chk_model(c);
      r = $urandom_range(0, 15);
      wd = $urandom;
      bus.A = BASE + 32'($urandom_range(0, 15));
      bus.WE = 1'b0;
      case (r)
        10: begin
          wd[15:8] = 8'($urandom_range(0, 3));
          wd[0] = ($urandom_range(0, 3) != 0);
          bus.A = BASE + 32'($urandom_range(0, 3)); bus.WE = 1'b1;
        end
        11: begin wd = 32'($urandom_range(0, 7)); bus.A = BASE + 32'h4; bus.WE = 1'b1; end
        12: begin wd = 32'($urandom_range(0, 7)); bus.A = BASE + 32'h8; bus.WE = 1'b1; end
        13: begin bus.A = BASE + 32'hC; bus.WE = 1'b1; end
        14: begin bus.A = BASE + 32'h10 + 32'($urandom_range(0, 15)); bus.WE = 1'b1; end
        15: begin bus.A = BASE - 32'h10 + 32'($urandom_range(0, 15)); bus.WE = 1'b1; end
        default: ;
      endcase
      bus.WD = wd;
      step();
      bus.WE = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
